// File: rtl/load_store_unit.sv
// Load/store unit: issues one memory read or write per accepted request,
// forwards ALU results on pass-through ops and flags memory timeouts.
module load_store_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] SR1,
    input  logic [DATA_W-1:0] SR2,
    input  logic [ADDR_W-1:0] offset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              RW,
    output logic [ADDR_W-1:0] add_bus,
    output logic [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] data_reg,
    output logic              LDR,
    output logic              STR,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] OP_LOAD   = 4'b1101;
    localparam logic [3:0] OP_STORE  = 4'b1110;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_r, next_state_s;
    logic              mem_req_r, mem_req_s;
    logic              rw_r, rw_s;
    logic [ADDR_W-1:0] add_bus_r, add_bus_s;
    logic [DATA_W-1:0] data_bus_r, data_bus_s;
    logic [DATA_W-1:0] data_reg_r, data_reg_s;
    logic              ldr_r, ldr_s;
    logic              str_r, str_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [7:0]        wait_cnt_r, wait_cnt_s;
    logic [7:0]        wait_inc_s;
    logic              sr1_unused_s;

    // Only the low ADDR_W bits of the base operand form the address.
    assign sr1_unused_s = ^SR1[DATA_W-1:ADDR_W];

    // State and output registers; reset clears everything and drops any request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            mem_req_r  <= 1'b0;
            rw_r       <= 1'b0;
            add_bus_r  <= {ADDR_W{1'b0}};
            data_bus_r <= {DATA_W{1'b0}};
            data_reg_r <= {DATA_W{1'b0}};
            ldr_r      <= 1'b0;
            str_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= next_state_s;
            mem_req_r  <= mem_req_s;
            rw_r       <= rw_s;
            add_bus_r  <= add_bus_s;
            data_bus_r <= data_bus_s;
            data_reg_r <= data_reg_s;
            ldr_r      <= ldr_s;
            str_r      <= str_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = mem_req_r;
        rw_s         = rw_r;
        add_bus_s    = add_bus_r;
        data_bus_s   = data_bus_r;
        data_reg_s   = data_reg_r;
        ldr_s        = ldr_r;
        str_s        = str_r;
        done_s       = 1'b0;
        err_s        = err_r;
        wait_cnt_s   = wait_cnt_r;
        wait_inc_s   = wait_cnt_r + 8'd1;

        case (state_r)
            IDLE: begin
                if (start) begin
                    err_s = 1'b0;
                    if ((op_code == OP_LOAD) || (op_code == OP_STORE)) begin
                        add_bus_s    = SR1[ADDR_W-1:0] + offset;
                        mem_req_s    = 1'b1;
                        wait_cnt_s   = 8'd0;
                        next_state_s = ACCESS;
                        if (op_code == OP_STORE) begin
                            data_bus_s = SR2;
                            rw_s       = 1'b0;
                            ldr_s      = 1'b0;
                            str_s      = 1'b1;
                        end else begin
                            rw_s  = 1'b1;
                            ldr_s = 1'b1;
                            str_s = 1'b0;
                        end
                    end else begin
                        data_reg_s   = alu_result;
                        next_state_s = FINISH;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                // An ack in the timeout cycle still completes normally.
                if (mem_ack) begin
                    mem_req_s    = 1'b0;
                    next_state_s = FINISH;
                    if (ldr_r) begin
                        data_reg_s = mem_rdata;
                    end else begin
                        data_reg_s = data_reg_r;
                    end
                end else if (wait_inc_s == TIMEOUT_C) begin
                    mem_req_s    = 1'b0;
                    err_s        = 1'b1;
                    wait_cnt_s   = wait_inc_s;
                    next_state_s = FINISH;
                end else begin
                    wait_cnt_s = wait_inc_s;
                end
            end
            FINISH: begin
                done_s       = 1'b1;
                ldr_s        = 1'b0;
                str_s        = 1'b0;
                next_state_s = IDLE;
            end
            default: begin
                mem_req_s    = 1'b0;
                ldr_s        = 1'b0;
                str_s        = 1'b0;
                next_state_s = IDLE;
            end
        endcase

        busy_s = (next_state_s != IDLE);
    end

    assign mem_req  = mem_req_r;
    assign RW       = rw_r;
    assign add_bus  = add_bus_r;
    assign data_bus = data_bus_r;
    assign data_reg = data_reg_r;
    assign LDR      = ldr_r;
    assign STR      = str_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: load, store with wrap,
// timeout, ack-at-timeout, pass-through, back-to-back and mid-access reset.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [3:0]  op_code;
    logic [31:0] SR1, SR2, alu_result, mem_rdata;
    logic [7:0]  offset;
    logic        mem_ack;
    logic        mem_req, RW, LDR, STR, busy, done, err;
    logic [7:0]  add_bus;
    logic [31:0] data_bus, data_reg;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op_code(op_code),
        .SR1(SR1), .SR2(SR2), .offset(offset), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .RW(RW),
        .add_bus(add_bus), .data_bus(data_bus), .data_reg(data_reg),
        .LDR(LDR), .STR(STR), .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_value({tag, " mem_req"},  64'(mem_req),  64'd0);
        chk_value({tag, " RW"},       64'(RW),       64'd0);
        chk_value({tag, " LDR"},      64'(LDR),      64'd0);
        chk_value({tag, " STR"},      64'(STR),      64'd0);
        chk_value({tag, " busy"},     64'(busy),     64'd0);
        chk_value({tag, " done"},     64'(done),     64'd0);
        chk_value({tag, " err"},      64'(err),      64'd0);
        chk_value({tag, " add_bus"},  64'(add_bus),  64'd0);
        chk_value({tag, " data_bus"}, 64'(data_bus), 64'd0);
        chk_value({tag, " data_reg"}, 64'(data_reg), 64'd0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; op_code = 4'b0000; SR1 = 32'd0; SR2 = 32'd0;
        offset = 8'd0; alu_result = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        tick; tick;
        chk_reset_state("reset");
        Reset = 1'b0;
        tick;

        // Load with ack in first ACCESS cycle
        SR1 = 32'h10; offset = 8'h05; op_code = 4'b1101; start = 1'b1;
        tick;
        start = 1'b0;
        chk_value("ld mem_req", 64'(mem_req), 64'd1);
        chk_value("ld RW",      64'(RW),      64'd1);
        chk_value("ld add_bus", 64'(add_bus), 64'h15);
        chk_value("ld LDR",     64'(LDR),     64'd1);
        chk_value("ld busy",    64'(busy),    64'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        mem_ack = 1'b0;
        chk_value("ld req drop", 64'(mem_req),  64'd0);
        chk_value("ld done e1",  64'(done),     64'd0);
        chk_value("ld data_reg", 64'(data_reg), 64'hDEADBEEF);
        tick;
        chk_value("ld done e2",  64'(done), 64'd1);
        chk_value("ld busy off", 64'(busy), 64'd0);
        chk_value("ld LDR off",  64'(LDR),  64'd0);
        tick;
        chk_value("ld done once", 64'(done), 64'd0);

        // Store with address wrap, ack on 4th ACCESS cycle
        SR1 = 32'hFE; offset = 8'h03; SR2 = 32'h12345678; op_code = 4'b1110; start = 1'b1;
        tick;
        start = 1'b0;
        chk_value("st add_bus", 64'(add_bus),  64'h01);
        chk_value("st RW",      64'(RW),       64'd0);
        chk_value("st data_bus",64'(data_bus), 64'h12345678);
        chk_value("st STR",     64'(STR),      64'd1);
        tick; tick; tick;
        chk_value("st req held",  64'(mem_req), 64'd1);
        chk_value("st addr held", 64'(add_bus), 64'h01);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        tick;
        mem_ack = 1'b0;
        chk_value("st req drop", 64'(mem_req),  64'd0);
        chk_value("st data_reg", 64'(data_reg), 64'hDEADBEEF);
        chk_value("st err",      64'(err),      64'd0);
        tick;
        chk_value("st done", 64'(done), 64'd1);
        tick;

        // Timeout: 15 ACCESS cycles with no ack
        SR1 = 32'h20; offset = 8'h00; op_code = 4'b1101; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick;
        chk_value("to req at 15", 64'(mem_req), 64'd1);
        chk_value("to err early", 64'(err),     64'd0);
        tick;
        chk_value("to req drop", 64'(mem_req),  64'd0);
        chk_value("to err",      64'(err),      64'd1);
        chk_value("to data_reg", 64'(data_reg), 64'hDEADBEEF);
        tick;
        chk_value("to done", 64'(done), 64'd1);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        chk_value("to done once",    64'(done),    64'd0);
        chk_value("to err sticky",   64'(err),     64'd0 + 64'd1);
        chk_value("idle ack ignored",64'(mem_req), 64'd0);
        chk_value("idle ack busy",   64'(busy),    64'd0);

        // Pass-through; the accepted start clears err
        op_code = 4'b0000; alu_result = 32'hA5A5A5A5; start = 1'b1;
        tick;
        start = 1'b0;
        chk_value("pt mem_req",  64'(mem_req),  64'd0);
        chk_value("pt busy",     64'(busy),     64'd1);
        chk_value("pt data_reg", 64'(data_reg), 64'hA5A5A5A5);
        chk_value("pt err clr",  64'(err),      64'd0);
        tick;
        chk_value("pt done", 64'(done), 64'd1);

        // Back-to-back start in the done cycle
        op_code = 4'b0011; alu_result = 32'h5A5A5A5A; start = 1'b1;
        tick;
        start = 1'b0;
        chk_value("b2b data_reg", 64'(data_reg), 64'h5A5A5A5A);
        chk_value("b2b busy",     64'(busy),     64'd1);
        tick;
        chk_value("b2b done", 64'(done), 64'd1);
        tick;

        // Ack arriving in the same cycle the counter reaches TIMEOUT
        SR1 = 32'h40; offset = 8'h01; op_code = 4'b1101; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick;
        mem_ack = 1'b0;
        chk_value("ackto err",      64'(err),      64'd0);
        chk_value("ackto data_reg", 64'(data_reg), 64'hCAFEF00D);
        tick;
        chk_value("ackto done", 64'(done), 64'd1);
        tick;

        // Reset mid-ACCESS with a start pulsed while busy
        SR1 = 32'h33; offset = 8'h00; op_code = 4'b1101; start = 1'b1;
        tick;
        SR1 = 32'h77; SR2 = 32'h99; op_code = 4'b1110;
        tick;
        start = 1'b0;
        chk_value("busy start RW",  64'(RW),      64'd1);
        chk_value("busy start STR", 64'(STR),     64'd0);
        chk_value("busy start adr", 64'(add_bus), 64'h33);
        Reset = 1'b1;
        tick;
        chk_reset_state("mid reset");
        Reset = 1'b0;
        tick;
        chk_value("post rst done",    64'(done),    64'd0);
        chk_value("post rst mem_req", 64'(mem_req), 64'd0);
        tick;
        chk_value("post rst done2", 64'(done), 64'd0);
        chk_value("post rst busy",  64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_W, default 32: data path width in bits.
REQ-002 Parameter ADDR_W, default 8: memory address width in bits.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_ack, range 1..255.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request strobe; sampled only in IDLE.
REQ-007 op_code  input  4  operation: 4'b1101 load, 4'b1110 store, any other value is pass-through.
REQ-008 SR1  input  DATA_W  base address operand.
REQ-009 SR2  input  DATA_W  store data operand.
REQ-010 offset  input  ADDR_W  address offset.
REQ-011 alu_result  input  DATA_W  result forwarded on pass-through ops.
REQ-012 mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1.
REQ-013 mem_ack  input  1  memory completion strobe.
REQ-014 mem_req  output  1  memory request, held high until ack or timeout.
REQ-015 RW  output  1  access direction: 1 read, 0 write; valid while mem_req=1.
REQ-016 add_bus  output  ADDR_W  memory address.
REQ-017 data_bus  output  DATA_W  memory write data.
REQ-018 data_reg  output  DATA_W  registered result: load data or alu_result.
REQ-019 LDR, STR  output  1 each  registered flags marking the in-flight op type.
REQ-020 busy  output  1  high in every state except IDLE.
REQ-021 done  output  1  one-cycle completion pulse.
REQ-022 err  output  1  set on timeout; cleared at the next accepted start.

Function
REQ-023 FSM states are IDLE, ACCESS, FINISH; all outputs are registered.
REQ-024 In IDLE with start=1 and load/store op_code, the block latches add_bus = (SR1[ADDR_W-1:0] + offset) mod 2^ADDR_W.
REQ-025 On that same edge it latches data_bus = SR2 (store only), sets LDR or STR, RW = 1 (load) or 0 (store), mem_req = 1, and enters ACCESS.
REQ-026 In IDLE with start=1 and a pass-through op_code, the block latches data_reg = alu_result and enters FINISH, with no memory request.
REQ-027 In ACCESS, add_bus, data_bus and RW are held stable while mem_req=1.
REQ-028 In ACCESS with mem_ack=1: mem_req goes to 0 on the next edge; on a load, data_reg = mem_rdata; the FSM enters FINISH.
REQ-029 A wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
REQ-030 When the wait counter reaches TIMEOUT with no ack: mem_req goes to 0, err = 1, data_reg is unchanged, and the FSM enters FINISH.
REQ-031 If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and err stays 0.
REQ-032 FINISH: done = 1 for exactly one cycle; LDR and STR are cleared; the FSM returns to IDLE.
REQ-033 start while busy=1 is ignored and not queued.
REQ-034 mem_ack while not in ACCESS is ignored.
REQ-035 Minimum latency: start to done = 3 cycles for a load/store with ack in its first ACCESS cycle; 2 cycles for pass-through.
REQ-036 Back-to-back: a new start is accepted in the IDLE cycle immediately after done.
REQ-037 Address addition wraps silently; there is no overflow flag.

Reset
REQ-038 Reset=1 at a rising edge forces: state IDLE; mem_req, RW, LDR, STR, busy, done, err = 0; add_bus, data_bus, data_reg, wait counter = 0.
REQ-039 Reset takes priority over every other input, including mid-ACCESS; an in-flight request is dropped without a done pulse.

Verification
REQ-040 Load: SR1=0x10, offset=0x05, op 1101, start; mem_ack on the 1st ACCESS cycle with mem_rdata=0xDEADBEEF -> add_bus=0x15, RW=1, data_reg=0xDEADBEEF, done 3 cycles after start.
REQ-041 Store: SR1=0xFE, offset=0x03, SR2=0x12345678, op 1110; ack after 4 cycles -> add_bus=0x01 (wrap), RW=0, data_bus=0x12345678, data_reg unchanged, err=0.
REQ-042 Timeout: load with no ack, TIMEOUT=15 -> mem_req drops after 15 ACCESS cycles, err=1, done pulses once; the next start clears err.
REQ-043 Pass-through: op 0000, alu_result=0xA5A5A5A5 -> no mem_req, data_reg=0xA5A5A5A5, done 2 cycles after start.
REQ-044 Reset mid-ACCESS with start pulsed while busy -> all outputs match REQ-038 next cycle, no done pulse, and the ignored start produces no access.
